// File: rtl/alu_seq_if.sv
// ============================================================================
//  Module      : alu_seq_if
//  Description : Issue/result bundle between the control unit and alu_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   ALUControl;
    logic [N-1:0] Result;
    logic [3:0]   ALUFlags;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b, ALUControl,
        input  Result, ALUFlags, busy, done
    );

    modport slave (
        input  start, a, b, ALUControl,
        output Result, ALUFlags, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with start/busy/done handshake and an
//                iterative shift-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  wire logic  clk,
    input  wire logic  reset,
    alu_seq_if.slave   bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MULT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    localparam logic [2:0] c_AND = 3'b010;
    localparam logic [2:0] c_OR  = 3'b011;
    localparam logic [2:0] c_EOR = 3'b100;
    localparam logic [2:0] c_MUL = 3'b101;
    localparam logic [2:0] c_LSL = 3'b110;
    localparam logic [2:0] c_LSR = 3'b111;

    localparam logic [SW-1:0] c_LAST = SW'(N - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [N-1:0]  r_ma;
    logic [N-1:0]  r_mb;
    logic [N-1:0]  r_acc;
    logic [SW-1:0] r_count;
    logic [N-1:0]  r_result;
    logic [3:0]    r_flags;
    logic          r_busy;
    logic          r_done;

    logic          w_accept;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic [N-1:0]  w_acc_nxt;
    logic [N-1:0]  w_res_nxt;
    logic [3:0]    w_flags_nxt;

    logic [N-1:0]  w_alu_res;
    logic [3:0]    w_alu_flags;
    logic [N-1:0]  w_bop;
    logic [N:0]    w_sum;
    logic [N:0]    w_shl;
    logic [N:0]    w_shr;
    logic [SW-1:0] w_s;
    logic          w_c;
    logic          w_v;

    // Single-cycle ops are evaluated on the inputs at the acceptance edge,
    // i.e. exactly the values being latched, so the result lands one cycle later.
    always_comb begin
        w_s       = bus.b[SW-1:0];
        w_bop     = (bus.ALUControl == c_SUB) ? ~bus.b : bus.b;
        w_sum     = {1'b0, bus.a} + {1'b0, w_bop} + {{N{1'b0}}, bus.ALUControl == c_SUB};
        // The extra bit beyond the data holds the last bit shifted out.
        w_shl     = {1'b0, bus.a} << w_s;
        w_shr     = {bus.a, 1'b0} >> w_s;
        w_alu_res = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        case (bus.ALUControl)
            c_ADD, c_SUB: begin
                w_alu_res = w_sum[N-1:0];
                w_c       = w_sum[N];
                w_v       = (bus.a[N-1] == w_bop[N-1]) && (w_sum[N-1] != bus.a[N-1]);
            end
            c_AND:   w_alu_res = bus.a & bus.b;
            c_OR:    w_alu_res = bus.a | bus.b;
            c_EOR:   w_alu_res = bus.a ^ bus.b;
            c_LSL: begin
                w_alu_res = w_shl[N-1:0];
                w_c       = w_shl[N];
            end
            c_LSR: begin
                w_alu_res = w_shr[N:1];
                w_c       = w_shr[0];
            end
            default: w_alu_res = '0;
        endcase
        w_alu_flags = {w_alu_res[N-1], w_alu_res == '0, w_c, w_v};
    end

    assign w_acc_nxt = r_acc + (r_mb[0] ? r_ma : '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.ALUControl == c_MUL) ? c_MULT : c_DONE;
                end
            end
            c_MULT: begin
                if (r_count == c_LAST) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_accept    = (r_state == c_IDLE) && bus.start;
        w_busy_nxt  = (w_state_nxt != c_IDLE);
        w_done_nxt  = (w_state_nxt == c_DONE);
        w_res_nxt   = w_alu_res;
        w_flags_nxt = w_alu_flags;
        if (r_state == c_MULT) begin
            w_res_nxt   = w_acc_nxt;
            w_flags_nxt = {w_acc_nxt[N-1], w_acc_nxt == '0, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ma    <= bus.a;
                r_mb    <= bus.b;
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == c_MULT) begin
                r_acc   <= w_acc_nxt;
                r_ma    <= r_ma << 1;
                r_mb    <= r_mb >> 1;
                r_count <= r_count + 1'b1;
            end
            if (w_done_nxt) begin
                r_result <= w_res_nxt;
                r_flags  <= w_flags_nxt;
            end
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign bus.Result   = r_result;
    assign bus.ALUFlags = r_flags;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

`default_nettype wire
